// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - shared timing constants and phase enum for the LCD timing generator
// Purpose: default 480x272 panel timing, total-period derivations, and the
//          four-phase state type used by both the horizontal and vertical axis.
// Ports:   none (package)
package lcd_timing_pkg;

  localparam int H_ACTIVE_DEF = 480;
  localparam int H_FP_DEF     = 2;
  localparam int H_SYNC_DEF   = 41;
  localparam int H_BP_DEF     = 2;

  localparam int V_ACTIVE_DEF = 272;
  localparam int V_FP_DEF     = 2;
  localparam int V_SYNC_DEF   = 10;
  localparam int V_BP_DEF     = 2;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef enum logic [1:0] {
    PH_ACT   = 2'd0,
    PH_FRONT = 2'd1,
    PH_SYNCP = 2'd2,
    PH_BACK  = 2'd3
  } phase_t;

endpackage

// File: rtl/lcd_axis_counter.sv
// rtl/lcd_axis_counter.sv - one timing axis: position counter, 4-phase FSM, active/sync decode
// Purpose: counts 0..TOTAL-1 and tracks ACT/FRONT/SYNCP/BACK phases; active
//          and sync_n are registered from the next state so they line up with count.
// Ports:   clk, rst     - clock, synchronous active-high reset
//          hold         - force idle: count 0, active 0, sync_n 1
//          load         - restart at position 0 (active phase)
//          adv          - advance one position
//          count        - current position
//          active       - high while count < ACTIVE
//          sync_n       - low while in the sync phase
//          last         - combinational: count is TOTAL-1 (wraps on next advance)
module lcd_axis_counter
  import lcd_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         load,
  input  logic         adv,
  output logic [W-1:0] count,
  output logic         active,
  output logic         sync_n,
  output logic         last
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  // Last position of each phase; the phase changes on the advance leaving it.
  localparam logic [W-1:0] END_ACT  = W'(ACTIVE - 1);
  localparam logic [W-1:0] END_FP   = W'(ACTIVE + FP - 1);
  localparam logic [W-1:0] END_SYNC = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] END_ALL  = W'(TOTAL - 1);

  phase_t       state_q, state_d;
  logic [W-1:0] count_d;
  logic         active_d, sync_n_d;

  assign last = (count == END_ALL);

  always_comb begin
    state_d  = state_q;
    count_d  = count;
    active_d = 1'b0;
    sync_n_d = 1'b1;
    if (hold) begin
      state_d = PH_ACT;
      count_d = '0;
    end else if (load) begin
      state_d  = PH_ACT;
      count_d  = '0;
      active_d = 1'b1;
    end else begin
      if (adv) begin
        count_d = last ? '0 : count + 1'b1;
        case (state_q)
          PH_ACT:   if (count == END_ACT)  state_d = PH_FRONT;
          PH_FRONT: if (count == END_FP)   state_d = PH_SYNCP;
          PH_SYNCP: if (count == END_SYNC) state_d = PH_BACK;
          PH_BACK:  if (last)              state_d = PH_ACT;
          default:                         state_d = PH_ACT;
        endcase
      end
      // Decode from the next state so the flags carry no skew to count.
      active_d = (state_d == PH_ACT);
      sync_n_d = (state_d != PH_SYNCP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PH_ACT;
      count   <= '0;
      active  <= 1'b0;
      sync_n  <= 1'b1;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      active  <= active_d;
      sync_n  <= sync_n_d;
    end
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - RGB LCD panel timing generator (hsync/vsync/data enable)
// Purpose: horizontal and vertical axis counters with registered sync and
//          active flags, one-clock-delayed data enable, frame start pulse and
//          an optional completed-frame counter (macro LCD_TIMING_FRAME_CNT_EN;
//          when undefined frame_cnt is tied to 0).
// Ports:   clk_lcd     - pixel clock
//          rst         - synchronous active-high reset
//          disp_on     - run enable; low holds the timing idle at (0,0)
//          hcount_reg  - horizontal position
//          Vcount_reg  - vertical position
//          flagh/flagv - position inside the visible area on each axis
//          rgb_en      - panel data enable, (flagh & flagv) one clock later
//          hsync_n/vsync_n - active-low sync pulses
//          frame_start - one-clock pulse at (0,0)
//          frame_cnt   - completed frames, modulo 256
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk_lcd,
  input  logic       rst,
  input  logic       disp_on,
  output logic [9:0] hcount_reg,
  output logic [8:0] Vcount_reg,
  output logic       flagh,
  output logic       flagv,
  output logic       rgb_en,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  logic run_q;      // counters are live (the last clock was enabled)
  logic idle;
  logic start;      // first enabled clock: land on (0,0)
  logic h_adv;
  logic v_adv;
  logic h_last;
  logic v_last;
  logic full_wrap;  // (V_TOTAL-1, H_TOTAL-1) -> (0,0) on this clock

  assign idle      = rst | ~disp_on;
  assign start     = ~idle & ~run_q;
  assign h_adv     = ~idle & run_q;
  assign v_adv     = h_adv & h_last;
  assign full_wrap = v_adv & v_last;

  lcd_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (10)
  ) u_h (
    .clk    (clk_lcd),
    .rst    (rst),
    .hold   (idle),
    .load   (start),
    .adv    (h_adv),
    .count  (hcount_reg),
    .active (flagh),
    .sync_n (hsync_n),
    .last   (h_last)
  );

  lcd_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (9)
  ) u_v (
    .clk    (clk_lcd),
    .rst    (rst),
    .hold   (idle),
    .load   (start),
    .adv    (v_adv),
    .count  (Vcount_reg),
    .active (flagv),
    .sync_n (vsync_n),
    .last   (v_last)
  );

  always_ff @(posedge clk_lcd) begin
    if (rst) begin
      run_q       <= 1'b0;
      frame_start <= 1'b0;
      rgb_en      <= 1'b0;
    end else begin
      run_q       <= disp_on;
      frame_start <= disp_on & (start | full_wrap);
      // Forced low the moment disp_on drops so an aborted line emits no data.
      rgb_en      <= disp_on & flagh & flagv;
    end
  end

`ifdef LCD_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk_lcd) begin
    if (rst) begin
      frame_cnt_q <= 8'd0;
    end else if (full_wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - scoreboard testbench for lcd_timing_gen
module tb_lcd_timing_gen;

  localparam int HA  = 12;
  localparam int HFP = 2;
  localparam int HS  = 4;
  localparam int HB  = 2;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VB  = 2;
  localparam int HT  = HA + HFP + HS + HB;
  localparam int VT  = VA + VFP + VS + VB;

  logic       clk_lcd = 1'b0;
  logic       rst = 1'b1;
  logic       disp_on = 1'b1;
  logic [9:0] hcount_reg;
  logic [8:0] Vcount_reg;
  logic       flagh, flagv, rgb_en, hsync_n, vsync_n, frame_start;
  logic [7:0] frame_cnt;

  always #5 clk_lcd = ~clk_lcd;

  lcd_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk_lcd     (clk_lcd),
    .rst         (rst),
    .disp_on     (disp_on),
    .hcount_reg  (hcount_reg),
    .Vcount_reg  (Vcount_reg),
    .flagh       (flagh),
    .flagv       (flagv),
    .rgb_en      (rgb_en),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  typedef struct {
    int x;
    int y;
    bit fh;
    bit fv;
    bit de;
    bit hs;
    bit vs;
    bit fs;
    bit en;
    int fc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: pixel position and frame count as plain integers.
  bit m_run = 0;
  int m_x = 0;
  int m_y = 0;
  int m_fc = 0;
  bit m_pfh = 0;
  bit m_pfv = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit d);
    exp_t e;
    rst     = r;
    disp_on = d;
    if (r || !d) begin
      m_run = 0;
      m_x   = 0;
      m_y   = 0;
      if (r) m_fc = 0;
      e.en = 0;
      e.fs = 0;
    end else begin
      e.en = 1;
      if (!m_run) begin
        m_run = 1;
        m_x   = 0;
        m_y   = 0;
      end else begin
        m_x++;
        if (m_x == HT) begin
          m_x = 0;
          m_y++;
          if (m_y == VT) begin
            m_y = 0;
`ifdef LCD_TIMING_FRAME_CNT_EN
            m_fc = (m_fc + 1) % 256;
`endif
          end
        end
      end
      e.fs = (m_x == 0) && (m_y == 0);
    end
    e.x  = m_x;
    e.y  = m_y;
    e.fh = e.en && (m_x < HA);
    e.fv = e.en && (m_y < VA);
    e.hs = !(e.en && (m_x >= HA + HFP) && (m_x < HA + HFP + HS));
    e.vs = !(e.en && (m_y >= VA + VFP) && (m_y < VA + VFP + VS));
    e.de = e.en && m_pfh && m_pfv;
    m_pfh = e.fh;
    m_pfv = e.fv;
    e.fc = m_fc;
    q.push_back(e);
    @(posedge clk_lcd);
    #1;
  endtask

  // Monitor: one expected item per clock, compared half a period after the edge.
  int cyc = 0;
  int last_fs = -1;
  bit clean = 0;
  int de_cnt = 0;
  int vs_cnt = 0;
  int hs_cnt = 0;

  always @(negedge clk_lcd) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cyc++;
      chk("hcount", int'(hcount_reg), e.x);
      chk("vcount", int'(Vcount_reg), e.y);
      chk("flagh", int'(flagh), int'(e.fh));
      chk("flagv", int'(flagv), int'(e.fv));
      chk("rgb_en", int'(rgb_en), int'(e.de));
      chk("hsync_n", int'(hsync_n), int'(e.hs));
      chk("vsync_n", int'(vsync_n), int'(e.vs));
      chk("frame_start", int'(frame_start), int'(e.fs));
      chk("frame_cnt", int'(frame_cnt), e.fc);
      if (!e.en) clean = 0;
      if (frame_start) begin
        if (clean && last_fs >= 0) begin
          chk("frame_period", cyc - last_fs, HT * VT);
          chk("de_per_frame", de_cnt, HA * VA);
          chk("vsync_low_clks", vs_cnt, VS * HT);
          chk("hsync_low_clks", hs_cnt, HS * VT);
        end
        last_fs = cyc;
        clean   = 1;
        de_cnt  = 0;
        vs_cnt  = 0;
        hs_cnt  = 0;
      end
      if (rgb_en) de_cnt++;
      if (!vsync_n) vs_cnt++;
      if (!hsync_n) hs_cnt++;
    end
  end

  initial begin
    // Reset held with the display enabled, then released into a clean run.
    repeat (3) step(1'b1, 1'b1);
    repeat (2 * HT * VT + HT / 2) step(1'b0, 1'b1);

    // Abort mid-frame at a fixed position, idle 5 clocks, resume.
    for (int i = 0; i < HT * VT + 1; i++) begin
      if (m_x == 7 && m_y == 3) break;
      step(1'b0, 1'b1);
    end
    repeat (5) step(1'b0, 1'b0);
    repeat (HT * VT + 10) step(1'b0, 1'b1);

    // Random run lengths with idle gaps and occasional reset pulses.
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(1, 400)) step(1'b0, 1'b1);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) step(1'b1, 1'($urandom_range(0, 1)));
      else
        repeat ($urandom_range(1, 5)) step(1'b0, 1'b0);
    end

    repeat (2 * HT * VT + 5) step(1'b0, 1'b1);
`ifdef LCD_TIMING_FRAME_CNT_EN
    repeat (257 * HT * VT) step(1'b0, 1'b1);
`endif

    repeat (4) @(negedge clk_lcd);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
